grant_requester: RTL and testbench

Initiator side of the req/gnt/last grant protocol. On a start command it raises req and holds it while counting gnt cycles from the responder. It marks the final request cycle with a one-cycle last pulse, then drops req. It sits in front of the grant responder and drives that responder's req input directly, with no extra register stage.

---
 rtl/grant_req_pkg.sv | 18 +
 rtl/grant_wdog.sv | 44 ++++
 rtl/grant_requester.sv | 134 +++++++++++++
 tb/tb_grant_requester.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/grant_req_pkg.sv
// Shared types and helpers for the grant requester:
// the FSM state enum, the default count width and the burst-length decode.
package grant_req_pkg;

    localparam int CNT_W_DEF = 3;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        LAST
    } state_e;

    // A raw burst length of zero stands for the full 2**cnt_w grants.
    function automatic int unsigned target_of(input int unsigned raw, input int unsigned cnt_w);
        return (raw == 0) ? (32'd1 << cnt_w) : raw;
    endfunction

endpackage

// File: rtl/grant_wdog.sv
// Counts consecutive gnt-low cycles while enabled; expire is raised
// combinationally on the TIMEOUT-th such cycle.
module grant_wdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    input  logic gnt_i,
    output logic expire_o
);

    localparam int W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Saturates at LIMIT so a long stall never wraps back to a small count.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            if (gnt_i) begin
                cnt_d = '0;
            end else if (cnt_q != LIMIT) begin
                cnt_d = cnt_q + W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = enable_i && !gnt_i && (cnt_q == LIMIT);

endmodule

// File: rtl/grant_requester.sv
// Initiator side of the req/gnt/last protocol: holds req for a burst of
// grants, marks the final req cycle with last, then reports done.
module grant_requester
    import grant_req_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [CNT_W-1:0] num_grants_i,
    input  logic             gnt_i,
    output logic             req_o,
    output logic             last_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_timeout_o,
    output logic             spur_gnt_o,
    output logic [CNT_W-1:0] grant_count_o
);

    state_e           state_q, state_d;
    logic [CNT_W:0]   target_q, target_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             abort_q, abort_d;
    logic             req_q, req_d;
    logic             last_q, last_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             spur_q, spur_d;

    logic wd_clear;
    logic wd_enable;
    logic wd_expire;
    logic term_hit;

    assign wd_enable = (state_q == REQ);
    assign term_hit  = gnt_i && ({1'b0, count_q} == (target_q - (CNT_W+1)'(1)));

    grant_wdog #(
        .TIMEOUT(TIMEOUT)
    ) u_wdog (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (wd_clear),
        .enable_i (wd_enable),
        .gnt_i    (gnt_i),
        .expire_o (wd_expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            target_q <= '0;
            count_q  <= '0;
            abort_q  <= 1'b0;
            req_q    <= 1'b0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            spur_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            count_q  <= count_d;
            abort_q  <= abort_d;
            req_q    <= req_d;
            last_q   <= last_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            spur_q   <= spur_d;
        end
    end

    // Completion is checked before the watchdog so a terminal grant always wins.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        count_d  = count_q;
        abort_d  = abort_q;
        wd_clear = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d  = REQ;
                    target_d = (CNT_W+1)'(target_of(32'(num_grants_i), CNT_W));
                    count_d  = '0;
                    abort_d  = 1'b0;
                    wd_clear = 1'b1;
                end
            end
            REQ: begin
                if (gnt_i) begin
                    count_d = count_q + CNT_W'(1);
                end
                if (term_hit) begin
                    state_d = LAST;
                end else if (wd_expire) begin
                    state_d = LAST;
                    abort_d = 1'b1;
                end
            end
            LAST: begin
                state_d = IDLE;
                abort_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        req_d  = (state_d != IDLE);
        last_d = (state_d == LAST);
        busy_d = (state_d != IDLE);
        done_d = (state_q == LAST);
        err_d  = (state_q == LAST) && abort_q;
        spur_d = gnt_i && (state_q != REQ);
    end

    assign req_o         = req_q;
    assign last_o        = last_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign err_timeout_o = err_q;
    assign spur_gnt_o    = spur_q;
    assign grant_count_o = count_q;

endmodule

// File: tb/tb_grant_requester.sv
// Self-checking bench for grant_requester: each burst's outcome is predicted
// up front from its generated gnt pattern, then checked cycle by cycle.
module tb_grant_requester;

    localparam int CNT_W   = 3;
    localparam int TIMEOUT = 16;
    localparam int FULL    = 1 << CNT_W;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [CNT_W-1:0] numGrants;
    logic             gnt;
    logic             req;
    logic             last;
    logic             busy;
    logic             done;
    logic             errTimeout;
    logic             spurGnt;
    logic [CNT_W-1:0] grantCount;

    int testsRun    = 0;
    int testsFailed = 0;
    logic [CNT_W-1:0] expCount = '0;

    grant_requester #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start_i       (start),
        .num_grants_i  (numGrants),
        .gnt_i         (gnt),
        .req_o         (req),
        .last_o        (last),
        .busy_o        (busy),
        .done_o        (done),
        .err_timeout_o (errTimeout),
        .spur_gnt_o    (spurGnt),
        .grant_count_o (grantCount)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic checkCycle(input string phase, input logic eReq, input logic eLast,
                              input logic eBusy, input logic eDone, input logic eErr,
                              input logic eSpur, input logic [CNT_W-1:0] eCount);
        checkOutput({phase, ".req"}, 32'(req), 32'(eReq));
        checkOutput({phase, ".last"}, 32'(last), 32'(eLast));
        checkOutput({phase, ".busy"}, 32'(busy), 32'(eBusy));
        checkOutput({phase, ".done"}, 32'(done), 32'(eDone));
        checkOutput({phase, ".err_timeout"}, 32'(errTimeout), 32'(eErr));
        checkOutput({phase, ".spur_gnt"}, 32'(spurGnt), 32'(eSpur));
        checkOutput({phase, ".grant_count"}, 32'(grantCount), 32'(eCount));
    endtask

    task automatic applyStimulus(input logic s, input logic [CNT_W-1:0] n, input logic g);
        start     = s;
        numGrants = n;
        gnt       = g;
    endtask

    // One IDLE cycle with the given gnt; a high gnt must show up as spur_gnt.
    task automatic idleCycle(input logic g);
        applyStimulus(1'b0, CNT_W'($urandom), g);
        @(negedge clk);
        checkCycle("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, g, expCount);
    endtask

    // Starts a burst in the current IDLE cycle. The whole gnt pattern is drawn
    // first and the expected length and abort outcome derived from it directly.
    task automatic runBurst(input int n, input int pct);
        bit   pattern[$];
        int   target;
        int   total;
        int   lowRun;
        bit   aborted;
        bit   finished;
        bit   b;
        int   seen;
        logic late;
        target   = (n == 0) ? FULL : n;
        total    = 0;
        lowRun   = 0;
        aborted  = 0;
        finished = 0;
        while (!finished) begin
            b = ($urandom_range(1, 100) <= pct);
            pattern.push_back(b);
            if (b) begin
                total++;
                lowRun = 0;
                if (total == target) finished = 1;
            end else begin
                lowRun++;
                if (lowRun == TIMEOUT) begin
                    finished = 1;
                    aborted  = 1;
                end
            end
        end
        applyStimulus(1'b1, CNT_W'(n), 1'b0);
        seen = 0;
        foreach (pattern[i]) begin
            @(negedge clk);
            checkCycle("req", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, CNT_W'(seen));
            applyStimulus(1'($urandom_range(0, 1)), CNT_W'($urandom), pattern[i]);
            seen += int'(pattern[i]);
        end
        @(negedge clk);
        checkCycle("last", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, CNT_W'(total % FULL));
        late = 1'($urandom_range(0, 1));
        applyStimulus(1'($urandom_range(0, 1)), CNT_W'($urandom), late);
        @(negedge clk);
        expCount = CNT_W'(total % FULL);
        checkCycle("done", 1'b0, 1'b0, 1'b0, 1'b1, aborted, late, expCount);
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, '0, 1'b0);
        repeat (2) @(negedge clk);
        checkCycle("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        reset = 1'b0;
        idleCycle(1'b0);

        // Basic, max-length and timeout bursts.
        runBurst(2, 100);
        idleCycle(1'b0);
        runBurst(0, 100);
        idleCycle(1'b0);
        runBurst(2, 0);

        // Back-to-back: next start lands in the done cycle.
        runBurst(2, 100);
        runBurst(2, 100);

        // Spurious gnt while idle, including right after done.
        idleCycle(1'b1);
        idleCycle(1'b1);
        idleCycle(1'b0);

        // Reset mid-burst after one grant, then a fresh basic burst.
        applyStimulus(1'b1, CNT_W'(2), 1'b0);
        @(negedge clk);
        checkCycle("rst_req0", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        applyStimulus(1'b0, CNT_W'(2), 1'b1);
        @(negedge clk);
        checkCycle("rst_req1", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, CNT_W'(1));
        applyStimulus(1'b0, CNT_W'(2), 1'b0);
        reset = 1'b1;
        @(negedge clk);
        checkCycle("rst_mid", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        reset    = 1'b0;
        expCount = '0;
        idleCycle(1'b0);
        runBurst(2, 100);

        // Randomised bursts with random lengths, grant densities and gaps.
        for (int k = 0; k < 60; k++) begin
            int gaps;
            int pct;
            gaps = $urandom_range(0, 2);
            for (int j = 0; j < gaps; j++) idleCycle(1'($urandom_range(0, 1)));
            case ($urandom_range(0, 5))
                0:       pct = 0;
                1:       pct = 100;
                default: pct = $urandom_range(30, 95);
            endcase
            runBurst($urandom_range(0, FULL - 1), pct);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
